// File: rtl/demux8b1x2_buf.sv
// demux8b1x2_buf: byte demultiplexer steering each input into one of two handshaked FIFO channels
module demux8b1x2_buf_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   ready,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] lvl
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic pop;
  assign valid = lvl != '0;
  assign pop = valid & ready;
  assign rdata = mem[rp];
  // push is pre-qualified by the caller against a full channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      lvl <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wp] <= wdata;
        wp <= wp + AW'(1);
      end
      if (pop) rp <= rp + AW'(1);
      lvl <= lvl + LW'(push) - LW'(pop);
    end
  end
endmodule

module demux8b1x2_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in,
  input  logic                   sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out0,
  output logic                   out0_valid,
  input  logic                   out0_ready,
  output logic [WIDTH-1:0]       out1,
  output logic                   out1_valid,
  input  logic                   out1_ready,
  output logic [$clog2(DEPTH):0] lvl0,
  output logic [$clog2(DEPTH):0] lvl1
);
  localparam int LW = $clog2(DEPTH) + 1;
  logic acc;
  assign in_ready = sel ? (lvl1 != LW'(DEPTH)) : (lvl0 != LW'(DEPTH));
  assign acc = in_valid & in_ready;
  demux8b1x2_buf_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ch0 (
    .clk(clk), .rst_n(rst_n), .push(acc & ~sel), .ready(out0_ready),
    .wdata(in), .rdata(out0), .valid(out0_valid), .lvl(lvl0)
  );
  demux8b1x2_buf_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ch1 (
    .clk(clk), .rst_n(rst_n), .push(acc & sel), .ready(out1_ready),
    .wdata(in), .rdata(out1), .valid(out1_valid), .lvl(lvl1)
  );
endmodule

// File: tb/tb_demux8b1x2_buf.sv
// tb_demux8b1x2_buf: directed and random checks of demux8b1x2_buf against a queue model
module tb_demux8b1x2_buf;
  localparam int DEPTH = 2;
  localparam int LW = $clog2(DEPTH) + 1;
  logic clk = 0, rst_n = 0;
  logic [7:0] in = 0;
  logic sel = 0, in_valid = 0, out0_ready = 0, out1_ready = 0;
  logic in_ready, out0_valid, out1_valid;
  logic [7:0] out0, out1;
  logic [LW-1:0] lvl0, lvl1;
  int checks = 0, errors = 0;
  logic [7:0] q0[$], q1[$];

  demux8b1x2_buf #(.WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .sel(sel), .in_valid(in_valid), .in_ready(in_ready),
    .out0(out0), .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out1(out1), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .lvl0(lvl0), .lvl1(lvl1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_state();
    check("out0_valid", out0_valid, q0.size() > 0);
    check("out1_valid", out1_valid, q1.size() > 0);
    check("lvl0", lvl0, q0.size());
    check("lvl1", lvl1, q1.size());
    if (q0.size() > 0) check("out0", out0, q0[0]);
    if (q1.size() > 0) check("out1", out1, q1[0]);
  endtask

  task automatic cyc(input logic v, input logic s, input logic [7:0] d, input logic r0, input logic r1);
    bit acc, p0, p1;
    in_valid = v; sel = s; in = d; out0_ready = r0; out1_ready = r1;
    #1;
    check("in_ready", in_ready, (s ? q1.size() : q0.size()) < DEPTH);
    acc = v && ((s ? q1.size() : q0.size()) < DEPTH);
    p0 = r0 && q0.size() > 0;
    p1 = r1 && q1.size() > 0;
    if (p0) void'(q0.pop_front());
    if (p1) void'(q1.pop_front());
    if (acc && !s) q0.push_back(d);
    if (acc && s) q1.push_back(d);
    @(posedge clk);
    #1;
    compare_state();
  endtask

  task automatic do_reset();
    in_valid = 0; out0_ready = 0; out1_ready = 0;
    #2 rst_n = 0;
    #1;
    check("rst_out0_valid", out0_valid, 0);
    check("rst_out1_valid", out1_valid, 0);
    check("rst_lvl0", lvl0, 0);
    check("rst_lvl1", lvl1, 0);
    check("rst_out0", out0, 8'h00);
    check("rst_out1", out1, 8'h00);
    check("rst_in_ready", in_ready, 1);
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    #3;
    check("init_out0_valid", out0_valid, 0);
    check("init_lvl0", lvl0, 0);
    check("init_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1;
    // reset mid-stream with channel 0 holding two bytes
    cyc(1, 0, 8'h5a, 0, 0);
    cyc(1, 0, 8'h5b, 0, 0);
    check("pre_rst_lvl0", lvl0, 2);
    do_reset();
    // steering and per-channel order
    cyc(1, 0, 8'hA1, 0, 0);
    cyc(1, 1, 8'hB2, 0, 0);
    cyc(1, 0, 8'hA3, 0, 0);
    check("steer_lvl0", lvl0, 2);
    check("steer_lvl1", lvl1, 1);
    check("steer_out0", out0, 8'hA1);
    check("steer_out1", out1, 8'hB2);
    cyc(0, 0, 8'h00, 1, 0);
    check("drain_out0", out0, 8'hA3);
    cyc(0, 0, 8'h00, 1, 0);
    check("drain_valid0", out0_valid, 0);
    // full channel 1 backpressure, channel 0 still accepted
    do_reset();
    cyc(1, 1, 8'h10, 0, 0);
    cyc(1, 1, 8'h11, 0, 0);
    sel = 1; #1 check("full_rdy_sel1", in_ready, 0);
    sel = 0; #1 check("full_rdy_sel0", in_ready, 1);
    cyc(1, 1, 8'h12, 0, 0);
    cyc(1, 0, 8'h55, 0, 0);
    check("full_lvl0", lvl0, 1);
    check("full_out0", out0, 8'h55);
    check("full_out1", out1, 8'h10);
    // simultaneous push and pop
    do_reset();
    cyc(1, 0, 8'h20, 0, 0);
    cyc(1, 0, 8'h21, 1, 0);
    check("pp_lvl0", lvl0, 1);
    check("pp_out0", out0, 8'h21);
    // full channel popped while pushed: no pass-through
    do_reset();
    cyc(1, 0, 8'h30, 0, 0);
    cyc(1, 0, 8'h31, 0, 0);
    cyc(1, 0, 8'h32, 1, 0);
    check("fp_lvl0", lvl0, 1);
    check("fp_out0", out0, 8'h31);
    cyc(1, 0, 8'h32, 0, 0);
    check("fp_lvl0_next", lvl0, 2);
    // random wrap-around stress
    do_reset();
    for (int i = 0; i < 500; i++)
      cyc($urandom_range(0, 3) != 0, 1'($urandom), 8'($urandom),
          $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
    for (int i = 0; i < 2 * DEPTH; i++) cyc(0, 0, 8'h00, 1, 1);
    check("end_lvl0", lvl0, 0);
    check("end_lvl1", lvl1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
